demux_1to2_stream: RTL and testbench
====================================

# demux_1to2_stream

Registered 1-to-2 stream demultiplexer: one valid/ready input stream carries a data word plus a route-select bit, and each accepted word is delivered to exactly one of two valid/ready output streams. It sits in the calculator datapath behind the operand/result muxes, steering a computed result either to the display path (port 0) or the accumulator write-back path (port 1). Each output owns a one-entry buffer, so a stall on one destination does not block traffic bound for the other.

## Interface
- WIDTH, 8, data word width in bits (legal 1..32)

- clk  input  1  rising-edge clock; only clock
- rst_n  input  1  reset; synchronous and active-low
- in_val  input  1  input word valid
- in_rdy  output  1  block can accept the input word this cycle
- in_sel  input  1  destination: 0 → port 0, 1 → port 1; meaningful only while in_val=1
- in_data  input  WIDTH  input word
- out0_val  output  1  port 0 word valid
- out0_rdy  input  1  port 0 consumer ready
- out0_data  output  WIDTH  port 0 word
- out1_val  output  1  port 1 word valid
- out1_rdy  input  1  port 1 consumer ready
- out1_data  output  WIDTH  port 1 word

## Operation
- Per-port slot FSM, two states: EMPTY, FULL. outN_val = (slot N == FULL); outN_data = slot N data register.
- Input handshake: accept when in_val & in_rdy at the rising edge.
- in_rdy = (slot[in_sel] == EMPTY) | outN_rdy for N = in_sel. Combinational paths in_sel→in_rdy and outN_rdy→in_rdy are intentional.
- Output handshake N: fires when outN_val & outN_rdy at the rising edge.
- Slot N transitions:
  - EMPTY → FULL on accept with in_sel=N; data register ← in_data.
  - FULL → EMPTY on output fire with no accept for N.
  - FULL → FULL on simultaneous output fire and accept for N; data register ← new in_data (no bubble).
  - FULL → FULL with data held while outN_rdy=0.
- Slots are independent. A port-1 fire and a port-0 accept in the same cycle are both honoured.
- Ordering is preserved per port. No ordering is defined between ports.
- in_data and in_sel are ignored when in_val=0. Data registers load only on accept.
- No word is duplicated or dropped. Every accept produces exactly one output fire on the selected port.

## Timing
- Latency: word accepted at edge k appears on outN at edge k (visible during cycle k+1). Registered, 1 cycle.
- Throughput: 1 word/cycle per port while the consumer holds rdy=1.
- Reset, rst_n=0 sampled at an edge:
  - Both slots → EMPTY; out0_val=out1_val=0; out0_data=out1_data=0.
  - in_rdy reads 1 during the following cycle.
  - Reset overrides any simultaneous accept or fire.
  - Buffered words are discarded on reset mid-operation.
- During reset, in_rdy is don't-care. Bench must not count handshakes while rst_n=0.
- Outputs must not change between edges except in_rdy, which follows in_sel and outN_rdy combinationally.

## Configuration
- DEMUX_1TO2_STREAM_CNT_EN defined:
  - Adds output ports out0_cnt and out1_cnt, each 8-bit.
  - Each counts output fires on its port, wrapping 255 → 0.
  - Both reset to 0 under rst_n=0.
  - Counts are visible the cycle after the fire.
- Not defined: counter ports and logic are absent. All other behaviour is identical.

## Structure
- Shared package demux_pkg:
  - slot_state_t enum {EMPTY, FULL}
  - DEMUX_WIDTH_DEFAULT = 8
  - DEMUX_CNT_W = 8
- Sub-module demux_out_slot:
  - One-entry buffer with FSM, data register and optional counter.
  - Ports: clk, rst_n, wr_en, wr_data, val, rdy, data, wr_ok.
  - Instantiated twice.
- Top level: in_sel decode, in_rdy mux, wr_en gating.

## Test plan
- Reset then idle: rst_n=0 for 2 cycles → out0_val=out1_val=0, both data=0x00. First cycle after reset, in_sel=0 → in_rdy=1.
- Single route: send 0xA5 with sel=0, out0_rdy=1 → out0_val=1 with 0xA5 for exactly one cycle one edge later. out1_val stays 0.
- Independent stall: out1_rdy=0. Send 0x11 sel=1, then 0x22 sel=1, then 0x33 sel=0.
  - Slot 1 holds 0x11; in_rdy=0 while in_sel=1.
  - 0x33 is still accepted and delivered on port 0.
  - Raising out1_rdy delivers 0x11 then 0x22.
- Full-throughput pass-through: 16 back-to-back words with alternating sel and both rdy=1 → zero bubbles, in_rdy constantly 1, per-port order preserved.
- Reset mid-operation: slot 0 FULL with 0x5A and out0_rdy=0. Pulse rst_n=0 one cycle → out0_val=0, out0_data=0x00 next cycle; 0x5A never appears.
- With DEMUX_1TO2_STREAM_CNT_EN: 257 fires on port 0 → out0_cnt=1, out1_cnt=0.

Source files
------------

// File: rtl/demux_1to2_stream_pkg.sv
// demux_pkg: shared types and constants for the 1-to-2 stream demultiplexer.
//   slot_state_t        : per-output slot occupancy (EMPTY / FULL)
//   DEMUX_WIDTH_DEFAULT : default data word width
//   DEMUX_CNT_W         : width of the optional per-port fire counters
// Optional feature macro: DEMUX_1TO2_STREAM_CNT_EN (adds fire counters).
package demux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    localparam int DEMUX_WIDTH_DEFAULT = 8;
    localparam int DEMUX_CNT_W         = 8;

endpackage

// File: rtl/demux_1to2_stream_if.sv
// demux_1to2_stream_if: bundles the input stream and both output streams.
//   in_val/in_rdy/in_sel/in_data    : input stream with route-select bit
//   out0_val/out0_rdy/out0_data     : port 0 (display path)
//   out1_val/out1_rdy/out1_data     : port 1 (accumulator write-back path)
//   out0_cnt/out1_cnt               : fire counters, only with DEMUX_1TO2_STREAM_CNT_EN
// Modports:
//   slave  : the demux itself
//   master : the surrounding producer/consumers
import demux_pkg::*;

interface demux_1to2_stream_if #(
    parameter int WIDTH = DEMUX_WIDTH_DEFAULT
);
    logic             in_val;
    logic             in_rdy;
    logic             in_sel;
    logic [WIDTH-1:0] in_data;
    logic             out0_val;
    logic             out0_rdy;
    logic [WIDTH-1:0] out0_data;
    logic             out1_val;
    logic             out1_rdy;
    logic [WIDTH-1:0] out1_data;
`ifdef DEMUX_1TO2_STREAM_CNT_EN
    logic [DEMUX_CNT_W-1:0] out0_cnt;
    logic [DEMUX_CNT_W-1:0] out1_cnt;
`endif

    modport slave (
        input  in_val, in_sel, in_data, out0_rdy, out1_rdy,
        output in_rdy, out0_val, out0_data, out1_val, out1_data
`ifdef DEMUX_1TO2_STREAM_CNT_EN
        , output out0_cnt, out1_cnt
`endif
    );

    modport master (
        output in_val, in_sel, in_data, out0_rdy, out1_rdy,
        input  in_rdy, out0_val, out0_data, out1_val, out1_data
`ifdef DEMUX_1TO2_STREAM_CNT_EN
        , input out0_cnt, out1_cnt
`endif
    );

endinterface

// File: rtl/demux_1to2_stream_out_slot.sv
// demux_out_slot: one-entry output buffer with valid/ready handshake.
//   clk, rst_n : clock, synchronous active-low reset
//   wr_en      : write a new word this edge (already qualified by wr_ok)
//   wr_data    : word to write
//   val        : slot holds a word
//   rdy        : consumer ready
//   data       : buffered word (holds last loaded value when empty)
//   wr_ok      : slot can take a word this edge (empty, or draining now)
//   cnt        : output fire counter, only with DEMUX_1TO2_STREAM_CNT_EN
//
// state | meaning
// EMPTY | no word buffered, val=0
// FULL  | word buffered in data_q, val=1
import demux_pkg::*;

module demux_out_slot #(
    parameter int WIDTH = DEMUX_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             val,
    input  logic             rdy,
    output logic [WIDTH-1:0] data,
    output logic             wr_ok
`ifdef DEMUX_1TO2_STREAM_CNT_EN
    ,
    output logic [DEMUX_CNT_W-1:0] cnt
`endif
);

    slot_state_t      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             fire;

    assign val   = (state_q == FULL);
    assign data  = data_q;
    assign fire  = val & rdy;
    // A full slot that drains this edge can be refilled in the same edge.
    assign wr_ok = (state_q == EMPTY) | rdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (wr_en) begin
            state_d = FULL;
            data_d  = wr_data;
        end else if (fire) begin
            state_d = EMPTY;
        end
    end

`ifdef DEMUX_1TO2_STREAM_CNT_EN
    logic [DEMUX_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (fire) begin
            cnt_q <= cnt_q + DEMUX_CNT_W'(1);
        end
    end

    assign cnt = cnt_q;
`endif

endmodule

// File: rtl/demux_1to2_stream.sv
// demux_1to2_stream: registered 1-to-2 stream demultiplexer.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : demux_1to2_stream_if slave modport (input stream, two output streams)
// Each output has its own one-entry slot, so a stall on one destination never
// blocks traffic for the other. in_rdy depends combinationally on in_sel and
// the selected port's rdy.
// Optional feature macro: DEMUX_1TO2_STREAM_CNT_EN (per-port fire counters).
import demux_pkg::*;

module demux_1to2_stream #(
    parameter int WIDTH = DEMUX_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux_1to2_stream_if.slave    bus
);

    logic wr_ok0, wr_ok1;
    logic wr_en0, wr_en1;

    assign bus.in_rdy = bus.in_sel ? wr_ok1 : wr_ok0;
    assign wr_en0     = bus.in_val & ~bus.in_sel & wr_ok0;
    assign wr_en1     = bus.in_val &  bus.in_sel & wr_ok1;

    demux_out_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en0),
        .wr_data (bus.in_data),
        .val     (bus.out0_val),
        .rdy     (bus.out0_rdy),
        .data    (bus.out0_data),
        .wr_ok   (wr_ok0)
`ifdef DEMUX_1TO2_STREAM_CNT_EN
        ,
        .cnt     (bus.out0_cnt)
`endif
    );

    demux_out_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en1),
        .wr_data (bus.in_data),
        .val     (bus.out1_val),
        .rdy     (bus.out1_rdy),
        .data    (bus.out1_data),
        .wr_ok   (wr_ok1)
`ifdef DEMUX_1TO2_STREAM_CNT_EN
        ,
        .cnt     (bus.out1_cnt)
`endif
    );

endmodule

// File: tb/tb_demux_1to2_stream.sv
// Testbench for demux_1to2_stream. The reference model treats each port as a
// queue of at most one word: a word may enter when the queue is empty or its
// head leaves in the same cycle; the head leaves when the consumer is ready.
module tb_demux_1to2_stream;
    localparam int W = 8;

    logic clk;
    logic rst_n;

    demux_1to2_stream_if #(.WIDTH(W)) bus ();

    demux_1to2_stream #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // reference model
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] last0, last1;
    int acc_m0, acc_m1, fire_o0, fire_o1;

    task automatic model_clear();
        q0.delete();
        q1.delete();
        last0 = '0;
        last1 = '0;
    endtask

    task automatic apply_reset(input int n);
        rst_n        = 1'b0;
        bus.in_val   = 1'b0;
        bus.in_sel   = 1'b0;
        bus.in_data  = '0;
        bus.out0_rdy = 1'b1;
        bus.out1_rdy = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    // Called at posedge+1; drives one cycle, advances the model across the edge.
    task automatic cycle(input logic v, input logic s, input logic [W-1:0] d,
                         input logic r0, input logic r1,
                         output logic rdy_obs, output logic rdy_exp);
        logic acc, f0, f1;
        bus.in_val   = v;
        bus.in_sel   = s;
        bus.in_data  = d;
        bus.out0_rdy = r0;
        bus.out1_rdy = r1;
        #1;
        rdy_exp = s ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
        rdy_obs = bus.in_rdy;
        acc = v && rdy_exp;
        f0  = (q0.size() != 0) && r0;
        f1  = (q1.size() != 0) && r1;
        if (bus.out0_val === 1'b1 && r0) fire_o0++;
        if (bus.out1_val === 1'b1 && r1) fire_o1++;
        @(posedge clk);
        if (f0) void'(q0.pop_front());
        if (f1) void'(q1.pop_front());
        if (acc) begin
            if (s) begin q1.push_back(d); last1 = d; acc_m1++; end
            else   begin q0.push_back(d); last0 = d; acc_m0++; end
        end
        #1;
    endtask

    task automatic test_reset();
        apply_reset(2);
        bus.in_sel = 1'b0;
        #1;
        chk_cnt++;
        if (bus.in_rdy !== 1'b1) $display("FAIL reset_in_rdy: got %b want 1", bus.in_rdy); else pass_cnt++;
        chk_cnt++;
        if (bus.out0_val !== 1'b0) $display("FAIL reset_out0_val: got %b want 0", bus.out0_val); else pass_cnt++;
        chk_cnt++;
        if (bus.out1_val !== 1'b0) $display("FAIL reset_out1_val: got %b want 0", bus.out1_val); else pass_cnt++;
        chk_cnt++;
        if (bus.out0_data !== 8'h00) $display("FAIL reset_out0_data: got %h want 00", bus.out0_data); else pass_cnt++;
        chk_cnt++;
        if (bus.out1_data !== 8'h00) $display("FAIL reset_out1_data: got %h want 00", bus.out1_data); else pass_cnt++;
`ifdef DEMUX_1TO2_STREAM_CNT_EN
        chk_cnt++;
        if (bus.out0_cnt !== 8'd0 || bus.out1_cnt !== 8'd0)
            $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.out0_cnt, bus.out1_cnt); else pass_cnt++;
`endif
        #(4);
        @(posedge clk); #1;
    endtask

    task automatic test_single_route();
        logic ro, re;
        cycle(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1, ro, re);
        chk_cnt++;
        if (ro !== 1'b1) $display("FAIL single_in_rdy: got %b want 1", ro); else pass_cnt++;
        chk_cnt++;
        if (bus.out0_val !== 1'b1 || bus.out0_data !== 8'hA5)
            $display("FAIL single_out0: got val=%b data=%h want 1/a5", bus.out0_val, bus.out0_data); else pass_cnt++;
        chk_cnt++;
        if (bus.out1_val !== 1'b0) $display("FAIL single_out1_val: got %b want 0", bus.out1_val); else pass_cnt++;
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, ro, re);
        chk_cnt++;
        if (bus.out0_val !== 1'b0) $display("FAIL single_one_cycle: got %b want 0", bus.out0_val); else pass_cnt++;
    endtask

    task automatic test_independent_stall();
        logic ro, re;
        cycle(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, ro, re);
        chk_cnt++;
        if (bus.out1_val !== 1'b1 || bus.out1_data !== 8'h11)
            $display("FAIL stall_slot1_load: got val=%b data=%h want 1/11", bus.out1_val, bus.out1_data); else pass_cnt++;
        cycle(1'b1, 1'b1, 8'h22, 1'b1, 1'b0, ro, re);
        chk_cnt++;
        if (ro !== 1'b0) $display("FAIL stall_in_rdy: got %b want 0", ro); else pass_cnt++;
        chk_cnt++;
        if (bus.out1_data !== 8'h11) $display("FAIL stall_hold: got %h want 11", bus.out1_data); else pass_cnt++;
        cycle(1'b1, 1'b0, 8'h33, 1'b1, 1'b0, ro, re);
        chk_cnt++;
        if (ro !== 1'b1) $display("FAIL stall_other_rdy: got %b want 1", ro); else pass_cnt++;
        chk_cnt++;
        if (bus.out0_val !== 1'b1 || bus.out0_data !== 8'h33)
            $display("FAIL stall_port0: got val=%b data=%h want 1/33", bus.out0_val, bus.out0_data); else pass_cnt++;
        chk_cnt++;
        if (bus.out1_val !== 1'b1 || bus.out1_data !== 8'h11)
            $display("FAIL stall_still_11: got val=%b data=%h want 1/11", bus.out1_val, bus.out1_data); else pass_cnt++;
        cycle(1'b1, 1'b1, 8'h22, 1'b1, 1'b1, ro, re);
        chk_cnt++;
        if (ro !== 1'b1) $display("FAIL stall_release_rdy: got %b want 1", ro); else pass_cnt++;
        chk_cnt++;
        if (bus.out1_val !== 1'b1 || bus.out1_data !== 8'h22)
            $display("FAIL stall_release_22: got val=%b data=%h want 1/22", bus.out1_val, bus.out1_data); else pass_cnt++;
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, ro, re);
        chk_cnt++;
        if (bus.out0_val !== 1'b0 || bus.out1_val !== 1'b0)
            $display("FAIL stall_drained: got %b/%b want 0/0", bus.out0_val, bus.out1_val); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic ro, re;
        logic [W-1:0] d;
        int bad_rdy = 0, bad_out = 0;
        for (int i = 0; i < 16; i++) begin
            d = W'($urandom);
            cycle(1'b1, i[0], d, 1'b1, 1'b1, ro, re);
            if (ro !== 1'b1) bad_rdy++;
            if (i[0] == 1'b0) begin
                if (bus.out0_val !== 1'b1 || bus.out0_data !== d || bus.out1_val !== 1'b0) bad_out++;
            end else begin
                if (bus.out1_val !== 1'b1 || bus.out1_data !== d || bus.out0_val !== 1'b0) bad_out++;
            end
        end
        chk_cnt++;
        if (bad_rdy !== 0) $display("FAIL b2b_in_rdy: got %0d stalled cycles want 0", bad_rdy); else pass_cnt++;
        chk_cnt++;
        if (bad_out !== 0) $display("FAIL b2b_outputs: got %0d bad cycles want 0", bad_out); else pass_cnt++;
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, ro, re);
    endtask

    task automatic test_reset_mid();
        logic ro, re;
        int seen = 0;
        cycle(1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, ro, re);
        chk_cnt++;
        if (bus.out0_val !== 1'b1 || bus.out0_data !== 8'h5A)
            $display("FAIL mid_load: got val=%b data=%h want 1/5a", bus.out0_val, bus.out0_data); else pass_cnt++;
        apply_reset(1);
        chk_cnt++;
        if (bus.out0_val !== 1'b0 || bus.out0_data !== 8'h00)
            $display("FAIL mid_reset: got val=%b data=%h want 0/00", bus.out0_val, bus.out0_data); else pass_cnt++;
        repeat (3) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, ro, re);
            if (bus.out0_val !== 1'b0 || bus.out0_data === 8'h5A) seen++;
        end
        chk_cnt++;
        if (seen !== 0) $display("FAIL mid_discard: got %0d cycles showing 5a want 0", seen); else pass_cnt++;
    endtask

    task automatic test_random();
        logic ro, re, v, s, r0, r1;
        logic [W-1:0] d;
        int bad = 0;
        acc_m0 = 0; acc_m1 = 0; fire_o0 = 0; fire_o1 = 0;
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(3) != 0);
            s  = 1'($urandom);
            d  = W'($urandom);
            r0 = ($urandom_range(3) != 0);
            r1 = ($urandom_range(2) == 0);
            cycle(v, s, d, r0, r1, ro, re);
            if (ro !== re) bad++;
            if (bus.out0_val !== (q0.size() != 0) || bus.out0_data !== last0) bad++;
            if (bus.out1_val !== (q1.size() != 0) || bus.out1_data !== last1) bad++;
        end
        chk_cnt++;
        if (bad !== 0) $display("FAIL random_model: got %0d mismatched samples want 0", bad); else pass_cnt++;
        repeat (2) cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, ro, re);
        chk_cnt++;
        if (fire_o0 !== acc_m0) $display("FAIL random_port0_count: got %0d fires want %0d", fire_o0, acc_m0); else pass_cnt++;
        chk_cnt++;
        if (fire_o1 !== acc_m1) $display("FAIL random_port1_count: got %0d fires want %0d", fire_o1, acc_m1); else pass_cnt++;
    endtask

`ifdef DEMUX_1TO2_STREAM_CNT_EN
    task automatic test_cnt();
        logic ro, re;
        apply_reset(2);
        for (int i = 0; i < 257; i++) cycle(1'b1, 1'b0, W'(i), 1'b1, 1'b1, ro, re);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, ro, re);
        chk_cnt++;
        if (bus.out0_cnt !== 8'd1) $display("FAIL cnt_port0_wrap: got %0d want 1", bus.out0_cnt); else pass_cnt++;
        chk_cnt++;
        if (bus.out1_cnt !== 8'd0) $display("FAIL cnt_port1: got %0d want 0", bus.out1_cnt); else pass_cnt++;
    endtask
`endif

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        model_clear();
        @(posedge clk); #1;
        test_reset();
        test_single_route();
        test_independent_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef DEMUX_1TO2_STREAM_CNT_EN
        test_cnt();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
